mpadder_pipe_param: RTL

- Parametrised successor of the fixed 1027-bit multi-precision adder. Adds or subtracts two WIDTH-bit operands, or performs a conditional subtract, using one CHUNK-bit adder.
- The adder is iterated over NCH = ceil((WIDTH+1)/CHUNK) chunk cycles, with a carry register between chunks.
- Sits in the Montgomery datapath. Conditional-subtract mode provides the final modular reduction in a single operation.

---
 rtl/mpadder_pipe_param_if.sv | 24 ++
 rtl/mpadder_pipe_param.sv | 113 +++++++++++
 2 files changed

// File: rtl/mpadder_pipe_param_if.sv
// Request/response bundle for the chunked multi-precision adder.
// The requester drives operands and start; the adder returns the result and status.
interface mpadder_pipe_param_if #(
  parameter int WIDTH = 1027
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   result;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, op, in_a, in_b,
    input  result, borrow, busy, done
  );

  modport slave (
    input  start, op, in_a, in_b,
    output result, borrow, busy, done
  );
endinterface

// File: rtl/mpadder_pipe_param.sv
// Multi-precision add / sub / conditional-subtract using one CHUNK-bit adder
// iterated over NCH cycles, with a carry register between chunks.
module mpadder_pipe_param #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 206
) (
  input  logic                 clk,
  input  logic                 reset,
  mpadder_pipe_param_if.slave  bus
);

  localparam int NCH = (WIDTH + CHUNK) / CHUNK;  // ceil((WIDTH+1)/CHUNK)
  localparam int WI  = NCH * CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WI-1:0]    a_reg;
  logic [WI-1:0]    b_reg;
  logic [WIDTH-1:0] a_shadow;
  logic [1:0]       op_q;
  logic             carry;
  logic [WIDTH:0]   result_q;
  logic             borrow_q;

  logic             is_sub;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic [WI-1:0]    a_next;
  logic [WI-1:0]    b_next;
  logic [WIDTH:0]   res_next;
  logic             bor_next;

  assign is_sub  = (op_q == 2'b01) || (op_q == 2'b10);
  assign b_chunk = is_sub ? ~b_reg[CHUNK-1:0] : b_reg[CHUNK-1:0];
  assign sum     = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};

  // The fresh sum slice enters at the top, so after NCH shifts a_reg holds S in order.
  if (NCH > 1) begin : g_multi
    assign a_next = {sum[CHUNK-1:0], a_reg[WI-1:CHUNK]};
    assign b_next = {{CHUNK{1'b0}}, b_reg[WI-1:CHUNK]};
  end else begin : g_single
    assign a_next = sum[CHUNK-1:0];
    assign b_next = '0;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    res_next = a_next[WIDTH:0];
    bor_next = 1'b0;
    case (op_q)
      2'b01: bor_next = ~sum[CHUNK];
      2'b10: begin
        bor_next = ~sum[CHUNK];
        if (!sum[CHUNK]) res_next = {1'b0, a_shadow};
      end
      default: ;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      a_shadow <= '0;
      op_q     <= 2'b00;
      carry    <= 1'b0;
      result_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (bus.start) begin
            a_reg    <= WI'(bus.in_a);
            b_reg    <= WI'(bus.in_b);
            a_shadow <= bus.in_a;
            op_q     <= bus.op;
            carry    <= (bus.op == 2'b01) || (bus.op == 2'b10);
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_reg <= a_next;
          b_reg <= b_next;
          carry <= sum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NCH - 1)) begin
            result_q <= res_next;
            borrow_q <= bor_next;
            state    <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIN is the single done cycle and already accepts a new start.
  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_FIN);
  assign bus.result = result_q;
  assign bus.borrow = borrow_q;

endmodule
